// File: rtl/regfile_operand_fetch.sv
// Operand fetch: issues regfile reads, hides the synchronous-read latency
// and keeps every in-flight operand current by snooping writeback.
module regfile_operand_fetch #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DEPTH_LOG2-1:0] in_rs1_addr,
  input  logic                  in_rs1_use,
  input  logic [DEPTH_LOG2-1:0] in_rs2_addr,
  input  logic                  in_rs2_use,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  rf_rs1_read,
  output logic [DEPTH_LOG2-1:0] rf_rs1_addr,
  input  logic [WIDTH-1:0]      rf_rs1_rdata,
  output logic                  rf_rs2_read,
  output logic [DEPTH_LOG2-1:0] rf_rs2_addr,
  input  logic [WIDTH-1:0]      rf_rs2_rdata,
  input  logic                  wb_valid,
  input  logic [DEPTH_LOG2-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_rs1_data,
  output logic [WIDTH-1:0]      out_rs2_data,
  output logic [TAG_W-1:0]      out_tag
);

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [DEPTH_LOG2-1:0] a1;
    logic                  en1;
    logic [WIDTH-1:0]      d1;
    logic [DEPTH_LOG2-1:0] a2;
    logic                  en2;
    logic [WIDTH-1:0]      d2;
  } ent_t;

  // en* already excludes r0 and unused sources, so those never match.
  function automatic ent_t snoop(
    input ent_t                  e,
    input logic                  v,
    input logic [DEPTH_LOG2-1:0] a,
    input logic [WIDTH-1:0]      d
  );
    ent_t r;
    r = e;
    if (v && e.en1 && e.a1 == a) r.d1 = d;
    if (v && e.en2 && e.a2 == a) r.d2 = d;
    return r;
  endfunction

  logic                  s1_valid;
  logic [TAG_W-1:0]      s1_tag;
  logic [DEPTH_LOG2-1:0] s1_a1;
  logic                  s1_en1;
  logic                  s1_h1;
  logic [WIDTH-1:0]      s1_w1;
  logic [DEPTH_LOG2-1:0] s1_a2;
  logic                  s1_en2;
  logic                  s1_h2;
  logic [WIDTH-1:0]      s1_w2;

  logic skid_valid;
  ent_t skid_q;
  ent_t out_q;
  ent_t s1_ent;

  logic accept;
  logic in_en1;
  logic in_en2;
  logic out_free;

  assign in_ready = !rst && !skid_valid
                    && !(s1_valid && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign in_en1   = in_rs1_use && (in_rs1_addr != '0);
  assign in_en2   = in_rs2_use && (in_rs2_addr != '0);
  assign out_free = !out_valid || out_ready;

  assign rf_rs1_read = accept && in_en1;
  assign rf_rs2_read = accept && in_en2;
  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;

  assign out_rs1_data = out_q.d1;
  assign out_rs2_data = out_q.d2;
  assign out_tag      = out_q.tag;

  // Newest wins: wb this cycle, then wb seen at accept, then the regfile.
  always_comb begin
    s1_ent     = '0;
    s1_ent.tag = s1_tag;
    s1_ent.a1  = s1_a1;
    s1_ent.en1 = s1_en1;
    s1_ent.a2  = s1_a2;
    s1_ent.en2 = s1_en2;
    if (s1_en1) s1_ent.d1 = s1_h1 ? s1_w1 : rf_rs1_rdata;
    if (s1_en2) s1_ent.d2 = s1_h2 ? s1_w2 : rf_rs2_rdata;
    s1_ent = snoop(s1_ent, wb_valid, wb_addr, wb_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_tag     <= '0;
      s1_a1      <= '0;
      s1_en1     <= 1'b0;
      s1_h1      <= 1'b0;
      s1_w1      <= '0;
      s1_a2      <= '0;
      s1_en2     <= 1'b0;
      s1_h2      <= 1'b0;
      s1_w2      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      out_q      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_tag <= in_tag;
        s1_a1  <= in_rs1_addr;
        s1_en1 <= in_en1;
        s1_h1  <= wb_valid && in_en1 && (wb_addr == in_rs1_addr);
        s1_w1  <= wb_data;
        s1_a2  <= in_rs2_addr;
        s1_en2 <= in_en2;
        s1_h2  <= wb_valid && in_en2 && (wb_addr == in_rs2_addr);
        s1_w2  <= wb_data;
      end
      // Skid drains first so the request order is preserved.
      if (out_free) begin
        if (skid_valid) begin
          out_q      <= snoop(skid_q, wb_valid, wb_addr, wb_data);
          out_valid  <= 1'b1;
          skid_valid <= s1_valid;
          skid_q     <= s1_ent;
        end else if (s1_valid) begin
          out_q     <= s1_ent;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        out_q <= snoop(out_q, wb_valid, wb_addr, wb_data);
        if (skid_valid) begin
          skid_q <= snoop(skid_q, wb_valid, wb_addr, wb_data);
        end else if (s1_valid) begin
          skid_q     <= s1_ent;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule
